// File: rtl/fpmult_pkg.sv
// Purpose: shared constants for the FP multiplier result path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fpmult_pkg;

  localparam int DWIDTH         = 32;  // sign + exponent + mantissa
  localparam int FLAGW          = 5;   // IEEE exception flags
  localparam int FPMULT_LATENCY = 5;   // operand issue -> product valid
  localparam int FIFO_DEPTH     = 8;

  // Exception flag bit positions inside a FLAGW-wide flag vector
  localparam int FLAG_INVALID   = 4;
  localparam int FLAG_OVERFLOW  = 3;
  localparam int FLAG_UNDERFLOW = 2;
  localparam int FLAG_DIVZERO   = 1;
  localparam int FLAG_INEXACT   = 0;

endpackage

// File: rtl/fpmult_result_buffer_if.sv
// Purpose: bundles the issue handshake, multiplier product bus, result
//          stream and status of fpmult_result_buffer.
// Latency: n/a (wiring only).  Backpressure: n/a (wiring only).
// master = upstream/consumer side, slave = the buffer itself.
interface fpmult_result_buffer_if #(
  parameter int DWIDTH = fpmult_pkg::DWIDTH,
  parameter int FLAGW  = fpmult_pkg::FLAGW,
  parameter int DEPTH  = fpmult_pkg::FIFO_DEPTH,
  parameter int AW     = $clog2(DEPTH)
);
  logic              in_valid;
  logic              in_ready;
  logic [DWIDTH-1:0] mult_result;
  logic [FLAGW-1:0]  mult_flags;
  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] out_data;
  logic [FLAGW-1:0]  out_flags;
  logic [FLAGW-1:0]  sticky_flags;
  logic              flags_clr;
  logic [AW:0]       count;
  logic              overflow_err;

  modport master (
    output in_valid, mult_result, mult_flags, out_ready, flags_clr,
    input  in_ready, out_valid, out_data, out_flags, sticky_flags, count, overflow_err
  );

  modport slave (
    input  in_valid, mult_result, mult_flags, out_ready, flags_clr,
    output in_ready, out_valid, out_data, out_flags, sticky_flags, count, overflow_err
  );
endinterface

// File: rtl/fpmult_sync_fifo.sv
// Purpose: generic single-clock FIFO with occupancy count.
// Latency: push visible at dout/empty the cycle after the write.
// Backpressure: push while full is ignored unless a pop frees the slot the same cycle.
// Ports: clk, rst (async active-low), push/din, pop/dout, count, full, empty.
module fpmult_sync_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             wr_en, rd_en;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO may still accept
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/fpmult_result_buffer.sv
// Purpose: issues operands to a stall-free multiplier only when a FIFO slot is
//          guaranteed, captures each {result, flags} in order, keeps sticky flags.
// Latency: LATENCY+1 cycles from issue to out_valid through an empty buffer.
// Backpressure: in_ready drops when stored + in-flight results would reach DEPTH.
// Ports: clk, rst (async active-low), bus (slave modport of fpmult_result_buffer_if).
module fpmult_result_buffer #(
  parameter int DWIDTH  = fpmult_pkg::DWIDTH,
  parameter int FLAGW   = fpmult_pkg::FLAGW,
  parameter int LATENCY = fpmult_pkg::FPMULT_LATENCY,
  parameter int DEPTH   = fpmult_pkg::FIFO_DEPTH,
  parameter int AW      = $clog2(DEPTH)
) (
  input logic                    clk,
  input logic                    rst,
  fpmult_result_buffer_if.slave  bus
);
  import fpmult_pkg::*;

  // Wide enough for count (0..DEPTH) plus in-flight ops (0..LATENCY)
  localparam int CW = AW + 1 + $clog2(LATENCY + 1);

  logic [LATENCY-1:0]      vpipe;
  logic                    ready_en;
  logic                    issue, push, pop;
  logic [CW-1:0]           credit_used;
  logic [FLAGW-1:0]        push_flags;
  logic [DWIDTH+FLAGW-1:0] fifo_dout;
  logic [AW:0]             fifo_count;
  logic                    fifo_full, fifo_empty;

  // Credit uses registered state only: a pop this cycle frees credit next cycle
  assign credit_used  = CW'(fifo_count) + CW'($countones(vpipe));
  assign bus.in_ready = ready_en & (credit_used < CW'(DEPTH));
  assign issue        = bus.in_valid & bus.in_ready;
  assign push         = vpipe[LATENCY-1];
  assign pop          = bus.out_valid & bus.out_ready;
  assign push_flags   = push ? bus.mult_flags : '0;

  fpmult_sync_fifo #(
    .WIDTH (DWIDTH + FLAGW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({bus.mult_flags, bus.mult_result}),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.out_valid = ~fifo_empty;
  assign bus.count     = fifo_count;
  // Head is gated so the result bus reads zero whenever nothing is stored
  assign bus.out_data  = fifo_empty ? '0 : fifo_dout[DWIDTH-1:0];
  assign bus.out_flags = fifo_empty ? '0 : fifo_dout[DWIDTH+FLAGW-1:DWIDTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vpipe            <= '0;
      ready_en         <= 1'b0;
      bus.sticky_flags <= '0;
      bus.overflow_err <= 1'b0;
    end else begin
      // ready_en keeps in_ready low until the first edge after reset release
      ready_en <= 1'b1;
      vpipe    <= (vpipe << 1) | LATENCY'(issue);
      if (bus.flags_clr) bus.sticky_flags <= push_flags;
      else               bus.sticky_flags <= bus.sticky_flags | push_flags;
      // Unreachable under the credit scheme; flags a broken multiplier contract
      if (push & fifo_full & ~pop) bus.overflow_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fpmult_result_buffer.sv
module tb_fpmult_result_buffer;
  import fpmult_pkg::*;

  localparam int LAT  = FPMULT_LATENCY;
  localparam int DEP  = 8;
  localparam int HIST = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fpmult_result_buffer_if #(.DWIDTH(DWIDTH), .FLAGW(FLAGW), .DEPTH(DEP)) bus ();

  fpmult_result_buffer #(
    .DWIDTH(DWIDTH), .FLAGW(FLAGW), .LATENCY(LAT), .DEPTH(DEP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Product the behavioural multiplier computes for the operands of each cycle
  logic [DWIDTH-1:0] ph_d [HIST];
  logic [FLAGW-1:0]  ph_f [HIST];
  logic [DWIDTH-1:0] op_d;
  logic [FLAGW-1:0]  op_f;

  // Buffer model: stored results and issue cycles of ops still inside the multiplier
  typedef struct {
    logic [DWIDTH-1:0] d;
    logic [FLAGW-1:0]  f;
  } ent_t;
  ent_t             mq[$];
  int               pend[$];
  logic [FLAGW-1:0] m_sticky = '0;
  bit               live     = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit m_ready();
    return rst && live && ((mq.size() + pend.size()) < DEP);
  endfunction

  task automatic drive_mult();
    if (cyc >= LAT) begin
      bus.mult_result = ph_d[(cyc - LAT) % HIST];
      bus.mult_flags  = ph_f[(cyc - LAT) % HIST];
    end else begin
      bus.mult_result = $urandom;
      bus.mult_flags  = FLAGW'($urandom);
    end
  endtask

  task automatic compare_model();
    if (!rst) begin
      chk("rst_out_valid", 64'(bus.out_valid), 0);
      chk("rst_count", 64'(bus.count), 0);
      chk("rst_in_ready", 64'(bus.in_ready), 0);
      chk("rst_sticky", 64'(bus.sticky_flags), 0);
      chk("rst_overflow", 64'(bus.overflow_err), 0);
      chk("rst_out_data", 64'(bus.out_data), 0);
      chk("rst_out_flags", 64'(bus.out_flags), 0);
    end else begin
      chk("in_ready", 64'(bus.in_ready), 64'(m_ready()));
      chk("out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
      chk("count", 64'(bus.count), 64'(mq.size()));
      chk("sticky", 64'(bus.sticky_flags), 64'(m_sticky));
      chk("overflow", 64'(bus.overflow_err), 0);
      if (mq.size() != 0) begin
        chk("out_data", 64'(bus.out_data), 64'(mq[0].d));
        chk("out_flags", 64'(bus.out_flags), 64'(mq[0].f));
      end
    end
  endtask

  task automatic update_model();
    bit               iss, pop, psh;
    logic [FLAGW-1:0] fin;
    ent_t             e;
    if (!rst) begin
      mq.delete();
      pend.delete();
      m_sticky = '0;
      live     = 1'b0;
    end else begin
      iss = bus.in_valid && m_ready();
      pop = (mq.size() != 0) && bus.out_ready;
      psh = (pend.size() != 0) && (pend[0] == cyc - LAT);
      fin = '0;
      if (psh) begin
        e.d = ph_d[(cyc - LAT) % HIST];
        e.f = ph_f[(cyc - LAT) % HIST];
        fin = e.f;
      end
      m_sticky = bus.flags_clr ? fin : (m_sticky | fin);
      if (pop) void'(mq.pop_front());
      if (psh) begin
        void'(pend.pop_front());
        mq.push_back(e);
      end
      if (iss) pend.push_back(cyc);
      live = 1'b1;
    end
  endtask

  // Inputs for the current cycle are already driven; compare mid-cycle, step model
  task automatic cycle();
    ph_d[cyc % HIST] = op_d;
    ph_f[cyc % HIST] = op_f;
    @(negedge clk);
    compare_model();
    update_model();
    @(posedge clk);
    #1;
    cyc++;
    drive_mult();
    op_d = $urandom;
    op_f = FLAGW'($urandom);
  endtask

  task automatic idle(input int n);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.flags_clr = 1'b0;
    repeat (n) cycle();
  endtask

  initial begin
    int acc, t0, drops, gaps, maxc;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.flags_clr = 1'b0;
    op_d = $urandom;
    op_f = FLAGW'($urandom);
    drive_mult();

    // Reset with random inputs
    #1 rst = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("reset_out_valid_lit", 64'(bus.out_valid), 0);
    chk("reset_in_ready_lit", 64'(bus.in_ready), 0);
    chk("reset_count_lit", 64'(bus.count), 0);
    for (int i = 0; i < 4; i++) begin
      bus.in_valid  = 1'($urandom);
      bus.out_ready = 1'($urandom);
      bus.flags_clr = 1'($urandom);
      cycle();
    end
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.flags_clr = 1'b0;
    chk("release_cycle_in_ready_lit", 64'(bus.in_ready), 0);
    cycle();
    chk("after_release_in_ready_lit", 64'(bus.in_ready), 1);
    idle(2);

    // Single op through an empty buffer
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    op_d = 32'h40C0_0000;
    op_f = '0;
    t0 = cyc;
    cycle();
    bus.in_valid = 1'b0;
    repeat (5) cycle();
    chk("single_cycle_lit", 64'(cyc - t0), 6);
    chk("single_out_valid_lit", 64'(bus.out_valid), 1);
    chk("single_out_data_lit", 64'(bus.out_data), 64'h40C0_0000);
    chk("single_count_lit", 64'(bus.count), 1);
    bus.out_ready = 1'b1;
    cycle();
    bus.out_ready = 1'b0;
    chk("single_popped_count_lit", 64'(bus.count), 0);
    idle(3);

    // Backpressure: consumer stalled, upstream always valid
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.in_ready) acc++;
      if (i == 13) chk("bp_count13_lit", 64'(bus.count), 8);
      op_d = 32'h3F80_0000 + 32'(i);
      op_f = FLAGW'(i);
      cycle();
    end
    chk("bp_issues_lit", 64'(acc), 8);
    chk("bp_overflow_lit", 64'(bus.overflow_err), 0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("bp_drain_order_lit", 64'(bus.out_data), 64'(32'h3F80_0000 + 32'(k)));
      cycle();
    end
    chk("bp_drained_lit", 64'(bus.out_valid), 0);
    idle(3);

    // Full throughput
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    drops = 0; gaps = 0; maxc = 0;
    for (int i = 0; i < 100; i++) begin
      if (!bus.in_ready) drops++;
      if (int'(bus.count) > maxc) maxc = int'(bus.count);
      if (i >= 6 && !bus.out_valid) gaps++;
      cycle();
    end
    chk("tp_ready_drops_lit", 64'(drops), 0);
    chk("tp_gaps_lit", 64'(gaps), 0);
    chk("tp_max_count_le1", 64'(maxc <= 1), 1);
    idle(8);

    // Sticky flags accumulate, and a push in the clear cycle survives
    bus.flags_clr = 1'b1;
    cycle();
    bus.flags_clr = 1'b0;
    bus.in_valid  = 1'b1;
    op_f = 5'b00100;
    cycle();
    op_f = 5'b00010;
    cycle();
    bus.in_valid = 1'b0;
    repeat (5) cycle();
    chk("sticky_or_lit", 64'(bus.sticky_flags), 64'(5'b00110));
    bus.in_valid = 1'b1;
    op_f = 5'b00001;
    cycle();
    bus.in_valid = 1'b0;
    repeat (4) cycle();
    bus.flags_clr = 1'b1;
    cycle();
    bus.flags_clr = 1'b0;
    chk("sticky_clr_push_lit", 64'(bus.sticky_flags), 64'(5'b00001));
    idle(4);

    // Reset with 3 ops in the multiplier and 2 stored
    bus.out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = (i < 2 || i >= 4);
      op_d = 32'hA000_0000 + 32'(i);
      cycle();
    end
    bus.in_valid = 1'b0;
    chk("mid_stored_lit", 64'(bus.count), 2);
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid_lit", 64'(bus.out_valid), 0);
    chk("mid_rst_count_lit", 64'(bus.count), 0);
    chk("mid_rst_in_ready_lit", 64'(bus.in_ready), 0);
    chk("mid_rst_sticky_lit", 64'(bus.sticky_flags), 0);
    repeat (2) cycle();
    rst = 1'b1;
    cycle();
    chk("mid_release_in_ready_lit", 64'(bus.in_ready), 1);
    repeat (8) cycle();
    chk("mid_discard_count_lit", 64'(bus.count), 0);
    chk("mid_discard_valid_lit", 64'(bus.out_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fpmult_result_buffer.md
Name: fpmult_result_buffer

Overview:
Downstream companion to the 5-stage single-precision FP multiplier. The multiplier has no valid or stall. This block issues operands to it only when buffer space is guaranteed, tracks each issued operation through the fixed multiplier latency, and captures every {result, flags} pair into an in-order FIFO with a valid/ready output. It also keeps sticky IEEE exception flags for software.

Parameters:
DWIDTH, 32, result width (sign+exponent+mantissa)
FLAGW, 5, exception flag width
LATENCY, 5, cycles from operand issue to result on mult_result
DEPTH, 8, FIFO entries; power of two, >= 2
AW, $clog2(DEPTH), FIFO pointer width

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset (asserts immediately, released synchronously to clk)
in_valid  in  1  upstream has an operand pair driven into the multiplier this cycle
in_ready  out  1  operand accepted this cycle (issue = in_valid & in_ready)
mult_result  in  DWIDTH  multiplier product output
mult_flags  in  FLAGW  multiplier flag output
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head
out_data  out  DWIDTH  head product
out_flags  out  FLAGW  head flags
sticky_flags  out  FLAGW  OR of flags of all results pushed since reset or last clear
flags_clr  in  1  clears sticky_flags
count  out  AW+1  FIFO occupancy
overflow_err  out  1  sticky; a push was attempted while the FIFO was full

Behaviour:
- Reset (rst=0): all outputs 0 immediately. vpipe, pointers, count, sticky_flags and overflow_err cleared. in_ready goes 0 during reset and returns to 1 on the first cycle after release.
- vpipe[LATENCY-1:0] is a shift register. vpipe[0] <= issue, vpipe[i] <= vpipe[i-1].
- push = vpipe[LATENCY-1] & (cycle alignment: an issue in cycle t results in push in cycle t+LATENCY). mult_result/mult_flags are sampled into the FIFO at the end of cycle t+LATENCY.
- Earliest out_valid for that entry is cycle t+LATENCY+1.
- inflight = popcount(vpipe), or an equivalent up/down counter.
- in_ready = (count + inflight) < DEPTH, computed from registered state only. A pop in the current cycle frees credit from the next cycle, not the current one.
- With this credit scheme, push while full cannot occur. If it does, the entry is dropped, pointers are unchanged, and overflow_err is set until reset.
- pop = out_valid & out_ready. out_data/out_flags = mem[rd_ptr], stable while out_valid & !out_ready.
- Simultaneous push and pop: both take effect and count is unchanged. This is legal when full: the pop frees the slot being written, so no overflow.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH. out_valid = (count != 0).
- sticky_flags <= flags_clr ? (push ? mult_flags : 0) : sticky_flags | (push ? mult_flags : 0). A push in the clear cycle is therefore retained.
- Results leave in issue order. Latency through an empty buffer is LATENCY+1 cycles from issue to out_valid.
- Reset mid-operation: vpipe is cleared, so results of operations already inside the multiplier are never pushed and are silently discarded.

Decomposition:
- Package fpmult_pkg holds:
  - DWIDTH, FLAGW, FPMULT_LATENCY=5
  - flag bit indices: 4 invalid, 3 overflow, 2 underflow, 1 divzero, 0 inexact
- One sub-module: fpmult_sync_fifo, a parameterised width/depth FIFO with push/pop/count/full/empty and the same async active-low rst. The top holds vpipe, the credit logic and the sticky flags.

Test Plan:
- Reset: hold rst=0 with random inputs -> out_valid=0, count=0, sticky_flags=0, overflow_err=0, in_ready=0. Release -> in_ready=1 next cycle.
- Single op: issue at cycle 0; model drives mult_result=0x40C00000, mult_flags=0 at cycle 5 -> out_valid=1 at cycle 6 with out_data=0x40C00000, count=1. out_ready=1 at cycle 6 -> count=0 at cycle 7.
- Backpressure: out_ready=0, in_valid=1 continuously -> exactly 8 issues accepted, then in_ready=0. count reaches 8 at cycle 13, overflow_err stays 0. Drain yields the 8 results in issue order.
- Full throughput: out_ready=1, in_valid=1 for 100 cycles -> one result per cycle after 6-cycle fill, in_ready never drops, count stays at most 1.
- Sticky flags: pushes with flags 5'b00100 then 5'b00010 -> sticky_flags=5'b00110. flags_clr in the same cycle as a push with 5'b00001 -> sticky_flags=5'b00001.
- Reset mid-flight: 3 ops in vpipe and 2 entries stored, pulse rst=0 -> outputs 0 immediately. Results later presented on mult_result are never pushed; count stays 0.
